pixel_mixer: RTL

- Output compositing stage between the image ROM / text generator and the LCD panel pins.
- Takes the panel timing strobes (HD, VD, DEN), the RGB565 image word from the image ROM and the 1-bit text-glyph pixel. Produces time-aligned 8-bit R/G/B plus delayed timing strobes.
- Supports four overlay modes, including frame-counted text blinking.
- Clocked by the pixel clock, which the top level connects to CLK.

---
 rtl/pixel_mixer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pixel_mixer.sv
// pixel_mixer: final compositing stage in front of the LCD pins.
// Aligns the panel timing strobes with the ROM pixel path, expands RGB565
// to RGB888 and overlays the text glyph in one of four modes. A frame
// counter driven by falling edges of VD_in provides the text blink phase.
module pixel_mixer #(
    parameter int          ROM_LAT      = 1,
    parameter logic [23:0] TEXT_RGB     = 24'hFFFFFF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HD_in,
    input  logic        VD_in,
    input  logic        DEN_in,
    input  logic [15:0] Data,
    input  logic        Text_bit,
    input  logic [1:0]  Mode,
    output logic        HD,
    output logic        VD,
    output logic        DEN,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        Blink_phase
);

    // Idle timing word {hd, vd, den}: syncs inactive (high), no data.
    localparam logic [2:0] TIMING_IDLE = 3'b110;
    localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

    localparam logic [7:0] TEXT_R = TEXT_RGB[23:16];
    localparam logic [7:0] TEXT_G = TEXT_RGB[15:8];
    localparam logic [7:0] TEXT_B = TEXT_RGB[7:0];

    // Timing delay line, one entry per cycle of ROM read latency.
    logic [2:0] tdly [ROM_LAT];
    logic [2:0] tdly_tail;

    // Blink frame counter and VD_in history for falling-edge detection.
    logic [7:0] blink_cnt;
    logic       vd_prev;
    logic       vd_fall;

    // Stage-1 combinational signals.
    logic [7:0] img_r, img_g, img_b;
    logic [8:0] sum_r, sum_g, sum_b;
    logic       text_vis;
    logic [7:0] mix_r, mix_g, mix_b;

    assign tdly_tail = tdly[ROM_LAT-1];
    assign vd_fall   = vd_prev & ~VD_in;

    // Shift the timing strobes so they line up with Data/Text_bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tdly[i] <= TIMING_IDLE;
            end
        end else begin
            tdly[0] <= {HD_in, VD_in, DEN_in};
            for (int i = 1; i < ROM_LAT; i++) begin
                tdly[i] <= tdly[i-1];
            end
        end
    end

    // Stage 1: colour expansion, overlay selection and blanking.
    always_comb begin
        img_r    = {Data[15:11], Data[15:13]};
        img_g    = {Data[10:5],  Data[10:9]};
        img_b    = {Data[4:0],   Data[4:2]};
        sum_r    = {1'b0, img_r} + {1'b0, TEXT_R};
        sum_g    = {1'b0, img_g} + {1'b0, TEXT_G};
        sum_b    = {1'b0, img_b} + {1'b0, TEXT_B};
        text_vis = 1'b0;
        mix_r    = img_r;
        mix_g    = img_g;
        mix_b    = img_b;

        case (Mode)
            2'd1, 2'd2: text_vis = Text_bit;
            2'd3:       text_vis = Text_bit & Blink_phase;
            default:    text_vis = 1'b0;
        endcase

        if (text_vis) begin
            if (Mode == 2'd2) begin
                // Average of image and text colour; the 9-bit sum keeps the carry.
                mix_r = sum_r[8:1];
                mix_g = sum_g[8:1];
                mix_b = sum_b[8:1];
            end else begin
                mix_r = TEXT_R;
                mix_g = TEXT_G;
                mix_b = TEXT_B;
            end
        end

        if (!tdly_tail[0]) begin
            mix_r = 8'h00;
            mix_g = 8'h00;
            mix_b = 8'h00;
        end
    end

    // Output register: pixel and strobes leave on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            HD  <= 1'b1;
            VD  <= 1'b1;
            DEN <= 1'b0;
            R   <= 8'h00;
            G   <= 8'h00;
            B   <= 8'h00;
        end else begin
            HD  <= tdly_tail[2];
            VD  <= tdly_tail[1];
            DEN <= tdly_tail[0];
            R   <= mix_r;
            G   <= mix_g;
            B   <= mix_b;
        end
    end

    // Blink counter: counts undelayed VD_in falling edges in every mode.
    // The history flop follows VD_in even during reset, so a VD edge that
    // coincides with reset is consumed and not counted afterwards.
    always_ff @(posedge CLK) begin
        vd_prev <= VD_in;
        if (RST) begin
            blink_cnt   <= 8'h00;
            Blink_phase <= 1'b1;
        end else if (vd_fall) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= 8'h00;
                Blink_phase <= ~Blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'h01;
            end
        end
    end

endmodule
